game_session_ctrl: RTL and testbench

//  Top-level sequencer for one coin-catcher round: start -> 3 s ready countdown -> timed play -> game over.

---
 rtl/game_session_ctrl_pkg.sv | 26 ++
 rtl/game_session_ctrl_if.sv | 32 +++
 rtl/game_session_ctrl_tick_gen.sv | 32 +++
 rtl/game_session_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_session_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/game_session_ctrl_pkg.sv
// Shared definitions for the coin-catcher session controller.
//   state_t           : phase encodings as seen on the state output
//   SCORE_W / SEC_W   : score and seconds widths
//   *_DEF             : default round timing
//   sat_inc()         : saturating score increment
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int unsigned SCORE_W           = 10;
   localparam int unsigned SEC_W             = 8;
   localparam int unsigned GAME_SECONDS_DEF  = 60;
   localparam int unsigned READY_SECONDS_DEF = 3;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                  input logic [SCORE_W-1:0] max);
      return (v >= max) ? max : v + 1'b1;
   endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Button/status bundle between the input conditioning, the session
// controller and the display/coin-spawn logic.
//   master : drives start_btn, pause_btn, coin_hit; observes status
//   slave  : the session controller
interface game_session_ctrl_if;
   import game_pkg::*;

   logic               start_btn;
   logic               pause_btn;
   logic               coin_hit;
   logic [2:0]         state;
   logic [SEC_W-1:0]   seconds;
   logic               sec_tick;
   logic               play_en;
   logic               time_up;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;
   logic               new_record;

   modport master (
      output start_btn, pause_btn, coin_hit,
      input  state, seconds, sec_tick, play_en, time_up,
             score, high_score, new_record
   );

   modport slave (
      input  start_btn, pause_btn, coin_hit,
      output state, seconds, sec_tick, play_en, time_up,
             score, high_score, new_record
   );

endinterface

// File: rtl/game_session_ctrl_tick_gen.sv
// One-second prescaler for the session controller.
//   clk, reset : system clock, synchronous active-high reset
//   run        : advance the count (READY/PLAY)
//   clear      : force the count to 0 (wins over run)
//   tick       : high for the cycle the count sits at CLK_HZ-1 while running
// With run and clear both low the count is held, which is how PAUSE
// resumes mid-second.
module game_tick_gen #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int unsigned W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [W-1:0] cnt;

   assign tick = run && (cnt == W'(CLK_HZ - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/game_session_ctrl.sv
// Round sequencer: IDLE -> READY countdown -> timed PLAY (pausable) -> OVER.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : buttons/coin pulses in; state, seconds, sec_tick, play_en,
//                time_up, score, high_score, new_record out
// Owns the seconds counter, score and session high score; the prescaler
// lives in game_tick_gen.
module game_session_ctrl
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100_000_000,
   parameter int unsigned GAME_SECONDS  = GAME_SECONDS_DEF,
   parameter int unsigned READY_SECONDS = READY_SECONDS_DEF,
   parameter int unsigned SCORE_MAX     = 999
) (
   input  logic                clk,
   input  logic                reset,
   game_session_ctrl_if.slave  bus
);

   state_t             st;
   logic [SEC_W-1:0]   seconds;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] high_score;
   logic [SCORE_W-1:0] score_coin;
   logic               new_record;
   logic               play_en;
   logic               time_up;
   logic               tick;
   logic               run;
   logic               clear;
   logic               last_sec;

   assign run      = (st == ST_READY) || (st == ST_PLAY);
   assign last_sec = (seconds <= SEC_W'(1));
   // Outside READY/PLAY/PAUSE the prescaler sits at 0; the READY->PLAY
   // handover restarts it too (it wraps there anyway, kept explicit).
   assign clear    = (!run && (st != ST_PAUSE)) ||
                     ((st == ST_READY) && tick && last_sec);

   // Score including a coin caught this cycle; used for the final-tick
   // high-score compare so a last-moment coin counts.
   assign score_coin = bus.coin_hit ? sat_inc(score, SCORE_W'(SCORE_MAX)) : score;

   game_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clear (clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= ST_IDLE;
         seconds    <= SEC_W'(GAME_SECONDS);
         score      <= '0;
         high_score <= '0;
         new_record <= 1'b0;
         play_en    <= 1'b0;
         time_up    <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (bus.start_btn) begin
                  st      <= ST_READY;
                  seconds <= SEC_W'(READY_SECONDS);
                  score   <= '0;
               end
            end

            ST_READY: begin
               if (tick) begin
                  if (last_sec) begin
                     st      <= ST_PLAY;
                     seconds <= SEC_W'(GAME_SECONDS);
                     play_en <= 1'b1;
                  end else begin
                     seconds <= seconds - 1'b1;
                  end
               end
            end

            ST_PLAY: begin
               score <= score_coin;
               // Final tick wins over pause; a non-final tick still
               // decrements when pause lands on the same cycle.
               if (tick && last_sec) begin
                  st      <= ST_OVER;
                  seconds <= '0;
                  play_en <= 1'b0;
                  time_up <= 1'b1;
                  if (score_coin > high_score) begin
                     high_score <= score_coin;
                     new_record <= 1'b1;
                  end else begin
                     new_record <= 1'b0;
                  end
               end else begin
                  if (tick) begin
                     seconds <= seconds - 1'b1;
                  end
                  if (bus.pause_btn) begin
                     st      <= ST_PAUSE;
                     play_en <= 1'b0;
                  end
               end
            end

            ST_PAUSE: begin
               if (bus.pause_btn || bus.start_btn) begin
                  st      <= ST_PLAY;
                  play_en <= 1'b1;
               end
            end

            ST_OVER: begin
               if (bus.start_btn) begin
                  st         <= ST_READY;
                  seconds    <= SEC_W'(READY_SECONDS);
                  score      <= '0;
                  new_record <= 1'b0;
                  time_up    <= 1'b0;
               end
            end

            default: begin
               st      <= ST_IDLE;
               play_en <= 1'b0;
               time_up <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state      = st;
   assign bus.seconds    = seconds;
   assign bus.sec_tick   = tick;
   assign bus.play_en    = play_en;
   assign bus.time_up    = time_up;
   assign bus.score      = score;
   assign bus.high_score = high_score;
   assign bus.new_record = new_record;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl with CLK_HZ=4, GAME_SECONDS=5,
// READY_SECONDS=3. Instance 0 uses SCORE_MAX=999, instance 1 SCORE_MAX=3.
// Expected snapshots are queued with the cycle they apply to; a monitor
// on the falling edge pops and compares them.
module tb_game_session_ctrl;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [2:0]  st;
      logic [7:0]  sec;
      logic        tk;
      logic        pe;
      logic        tu;
      logic [9:0]  sc;
      logic [9:0]  hi;
      logic        nr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   exp_t        q0[$];
   exp_t        q1[$];

   game_session_ctrl_if bus0();
   game_session_ctrl_if bus1();

   game_session_ctrl #(
      .CLK_HZ (4), .GAME_SECONDS (5), .READY_SECONDS (3), .SCORE_MAX (999)
   ) dut (
      .clk (clk), .reset (reset), .bus (bus0.slave)
   );

   game_session_ctrl #(
      .CLK_HZ (4), .GAME_SECONDS (5), .READY_SECONDS (3), .SCORE_MAX (3)
   ) dut_sat (
      .clk (clk), .reset (reset), .bus (bus1.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic goto(input int unsigned n);
      while (cyc < n) step();
   endtask

   task automatic ex(input int inst, input string n, input logic [2:0] st,
                     input logic [7:0] sec, input logic tk, input logic pe,
                     input logic tu, input logic [9:0] sc, input logic [9:0] hi,
                     input logic nr);
      exp_t e;
      e.cyc = cyc; e.name = n; e.st = st; e.sec = sec; e.tk = tk; e.pe = pe;
      e.tu = tu; e.sc = sc; e.hi = hi; e.nr = nr;
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
   endtask

   task automatic cmp(input exp_t e, input exp_t g);
      vectors++;
      if (e.cyc != cyc ||
          {e.st, e.sec, e.tk, e.pe, e.tu, e.sc, e.hi, e.nr} !==
          {g.st, g.sec, g.tk, g.pe, g.tu, g.sc, g.hi, g.nr}) begin
         miscompares++;
         $display("FAIL %s cyc=%0d/%0d: got st=%0d sec=%0d tk=%0d pe=%0d tu=%0d sc=%0d hi=%0d nr=%0d want st=%0d sec=%0d tk=%0d pe=%0d tu=%0d sc=%0d hi=%0d nr=%0d",
                  e.name, cyc, e.cyc, g.st, g.sec, g.tk, g.pe, g.tu, g.sc, g.hi, g.nr,
                  e.st, e.sec, e.tk, e.pe, e.tu, e.sc, e.hi, e.nr);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e, g;
      while (q0.size() > 0 && q0[0].cyc <= cyc) begin
         e = q0.pop_front();
         g.st = bus0.state; g.sec = bus0.seconds; g.tk = bus0.sec_tick;
         g.pe = bus0.play_en; g.tu = bus0.time_up; g.sc = bus0.score;
         g.hi = bus0.high_score; g.nr = bus0.new_record;
         cmp(e, g);
      end
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
         e = q1.pop_front();
         g.st = bus1.state; g.sec = bus1.seconds; g.tk = bus1.sec_tick;
         g.pe = bus1.play_en; g.tu = bus1.time_up; g.sc = bus1.score;
         g.hi = bus1.high_score; g.nr = bus1.new_record;
         cmp(e, g);
      end
   end

   // Saturating instance: coin on final tick, then saturation round
   initial begin
      bus1.start_btn = 1'b0; bus1.pause_btn = 1'b0; bus1.coin_hit = 1'b0;
      goto(2);
      bus1.start_btn = 1'b1; step(); bus1.start_btn = 1'b0;
      goto(15);
      bus1.coin_hit = 1'b1; step(); step(); bus1.coin_hit = 1'b0;
      goto(17); ex(1, "sat_two_coins", 3'd2, 8'd5, 1'b0, 1'b1, 1'b0, 10'd2, 10'd0, 1'b0);
      goto(34); ex(1, "sat_final_tick", 3'd2, 8'd1, 1'b1, 1'b1, 1'b0, 10'd2, 10'd0, 1'b0);
      bus1.coin_hit = 1'b1; step(); bus1.coin_hit = 1'b0;
      ex(1, "sat_coin_on_final", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd3, 10'd3, 1'b1);
      goto(40);
      bus1.start_btn = 1'b1; step(); bus1.start_btn = 1'b0;
      ex(1, "sat_round2_ready", 3'd1, 8'd3, 1'b0, 1'b0, 1'b0, 10'd0, 10'd3, 1'b0);
      goto(53);
      bus1.coin_hit = 1'b1;
      for (int i = 0; i < 5; i++) step();
      bus1.coin_hit = 1'b0;
      ex(1, "sat_saturated", 3'd2, 8'd4, 1'b0, 1'b1, 1'b0, 10'd3, 10'd3, 1'b0);
      goto(73); ex(1, "sat_equal_no_record", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd3, 10'd3, 1'b0);
   end

   // Main instance
   initial begin
      reset = 1'b1;
      bus0.start_btn = 1'b0; bus0.pause_btn = 1'b0; bus0.coin_hit = 1'b0;
      goto(2);
      ex(0, "reset_state", 3'd0, 8'd5, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      reset = 1'b0;

      // Round 1: countdown timing, coins in READY ignored, 7 coins in PLAY
      bus0.start_btn = 1'b1; step(); bus0.start_btn = 1'b0;
      ex(0, "ready_entry", 3'd1, 8'd3, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      goto(4); bus0.coin_hit = 1'b1; step(); bus0.coin_hit = 1'b0;
      goto(6); ex(0, "ready_first_tick", 3'd1, 8'd3, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      goto(7); ex(0, "ready_dec", 3'd1, 8'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      goto(8); bus0.coin_hit = 1'b1; step(); bus0.coin_hit = 1'b0;
      goto(14); ex(0, "ready_last_tick", 3'd1, 8'd1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      goto(15); ex(0, "play_entry", 3'd2, 8'd5, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
      bus0.coin_hit = 1'b1;
      for (int i = 0; i < 7; i++) step();
      bus0.coin_hit = 1'b0;
      goto(23); ex(0, "play_seven_coins", 3'd2, 8'd3, 1'b0, 1'b1, 1'b0, 10'd7, 10'd0, 1'b0);
      goto(34); ex(0, "play_final_tick", 3'd2, 8'd1, 1'b1, 1'b1, 1'b0, 10'd7, 10'd0, 1'b0);
      goto(35); ex(0, "over_record", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd7, 1'b1);
      goto(40); ex(0, "over_hold", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd7, 1'b1);

      // Round 2: equal score is not a record
      bus0.start_btn = 1'b1; step(); bus0.start_btn = 1'b0;
      ex(0, "round2_ready", 3'd1, 8'd3, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(53); ex(0, "round2_play", 3'd2, 8'd5, 1'b0, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      bus0.coin_hit = 1'b1;
      for (int i = 0; i < 7; i++) step();
      bus0.coin_hit = 1'b0;
      goto(73); ex(0, "round2_no_record", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd7, 1'b0);

      // Round 3: long pause with held prescaler, then pause on ticks
      goto(75); bus0.start_btn = 1'b1; step(); bus0.start_btn = 1'b0;
      goto(93); bus0.pause_btn = 1'b1; step(); bus0.pause_btn = 1'b0;
      ex(0, "pause_entry", 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      bus0.coin_hit = 1'b1;
      goto(100); ex(0, "pause_hold_a", 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(120); ex(0, "pause_hold_b", 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(143); ex(0, "pause_hold_c", 3'd3, 8'd4, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      bus0.coin_hit = 1'b0; bus0.pause_btn = 1'b1; step(); bus0.pause_btn = 1'b0;
      ex(0, "resume", 3'd2, 8'd4, 1'b0, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(145); ex(0, "resume_tick", 3'd2, 8'd4, 1'b1, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(146); ex(0, "resume_dec", 3'd2, 8'd3, 1'b0, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(149); ex(0, "tick_with_pause", 3'd2, 8'd3, 1'b1, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      bus0.pause_btn = 1'b1; step(); bus0.pause_btn = 1'b0;
      ex(0, "pause_and_dec", 3'd3, 8'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(152); bus0.pause_btn = 1'b1; step(); bus0.pause_btn = 1'b0;
      goto(156); ex(0, "tick_after_resume", 3'd2, 8'd2, 1'b1, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      goto(160); ex(0, "final_with_pause", 3'd2, 8'd1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd7, 1'b0);
      bus0.pause_btn = 1'b1; step(); bus0.pause_btn = 1'b0;
      ex(0, "over_wins_pause", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd7, 1'b0);

      // Round 4: reset mid-PLAY, start during reset ignored
      goto(165); bus0.start_btn = 1'b1; step(); bus0.start_btn = 1'b0;
      goto(178); bus0.coin_hit = 1'b1;
      goto(181); bus0.coin_hit = 1'b0;
      goto(183); ex(0, "before_reset", 3'd2, 8'd4, 1'b0, 1'b1, 1'b0, 10'd3, 10'd7, 1'b0);
      reset = 1'b1; bus0.start_btn = 1'b1; step();
      reset = 1'b0; bus0.start_btn = 1'b0;
      ex(0, "mid_play_reset", 3'd0, 8'd5, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      ex(1, "sat_reset", 3'd0, 8'd5, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
      goto(186); ex(0, "start_in_reset_ignored", 3'd0, 8'd5, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0);

      goto(190);
      while (q0.size() > 0) begin
         vectors++; miscompares++;
         $display("FAIL %s: expectation never checked", q0[0].name);
         void'(q0.pop_front());
      end
      while (q1.size() > 0) begin
         vectors++; miscompares++;
         $display("FAIL %s: expectation never checked", q1[0].name);
         void'(q1.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
